// File: rtl/video_tx_pkg.sv
// rtl/video_tx_pkg.sv - config word layout, field ID constants, lock-state enum and decoded config struct
package video_tx_pkg;

  localparam int H_TOTAL_LSB     = 0;
  localparam int H_ACTIVE_LSB    = 12;
  localparam int H_SYNCLEN_LSB   = 24;
  localparam int H_BACKPORCH_LSB = 0;
  localparam int V_TOTAL_LSB     = 9;
  localparam int V_ACTIVE_LSB    = 20;
  localparam int INTERLACED_BIT  = 31;
  localparam int V_SYNCLEN_LSB   = 0;
  localparam int V_BACKPORCH_LSB = 4;

  localparam logic FID_ODD  = 1'b1;
  localparam logic FID_EVEN = 1'b0;

  typedef enum logic [1:0] {
    UNLOCKED,
    TRACKING,
    LOCKED
  } lock_state_e;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_active;
    logic [7:0]  h_synclen;
    logic [8:0]  h_backporch;
    logic [10:0] v_total;
    logic [10:0] v_active;
    logic        interlaced;
    logic [3:0]  v_synclen;
    logic [8:0]  v_backporch;
  } video_cfg_t;

  function automatic video_cfg_t decode_cfg(input logic [31:0] c1,
                                            input logic [31:0] c2,
                                            input logic [12:0] c3);
    video_cfg_t c;
    c.h_total     = c1[H_TOTAL_LSB +: 12];
    c.h_active    = c1[H_ACTIVE_LSB +: 12];
    c.h_synclen   = c1[H_SYNCLEN_LSB +: 8];
    c.h_backporch = c2[H_BACKPORCH_LSB +: 9];
    c.v_total     = c2[V_TOTAL_LSB +: 11];
    c.v_active    = c2[V_ACTIVE_LSB +: 11];
    c.interlaced  = c2[INTERLACED_BIT];
    c.v_synclen   = c3[V_SYNCLEN_LSB +: 4];
    c.v_backporch = c3[V_BACKPORCH_LSB +: 9];
    return c;
  endfunction

endpackage

// File: rtl/video_tx_framelock.sv
// rtl/video_tx_framelock.sv - framelock FSM: counts in-phase reference pulses, requests resync otherwise
module video_tx_framelock
  import video_tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic lock_en,
  input  logic vsync_ref,
  input  logic frame_wrap,
  output logic resync,
  output logic locked
);

  lock_state_e state, state_n;
  logic [1:0]  match_cnt, match_cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNLOCKED;
      match_cnt <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_cnt_n;
    end
  end

  // A reference pulse on the last cycle of a frame is in phase; anything else re-aligns the counters.
  always_comb begin
    state_n     = state;
    match_cnt_n = match_cnt;
    resync      = 1'b0;
    if (!lock_en) begin
      state_n     = UNLOCKED;
      match_cnt_n = '0;
    end else if (vsync_ref) begin
      if (frame_wrap) begin
        if (match_cnt != 2'd3) match_cnt_n = match_cnt + 2'd1;
        state_n = (match_cnt_n == 2'd3) ? LOCKED : TRACKING;
      end else begin
        resync      = 1'b1;
        state_n     = UNLOCKED;
        match_cnt_n = '0;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/video_tx_timing_gen.sv
// rtl/video_tx_timing_gen.sv - video sync/DE timing generator with framelock
// VIDEO_TX_INTERLACE_EN enables interlaced field generation; otherwise FID_o is tied odd.
module video_tx_timing_gen
  import video_tx_pkg::*;
(
  input  logic        PCLK_i,
  input  logic        reset_i,
  input  logic [31:0] hv_out_config,
  input  logic [31:0] hv_out_config2,
  input  logic [31:0] hv_out_config3,
  input  logic        vsync_ref_i,
  input  logic        lock_en_i,
  output logic        HSYNC_o,
  output logic        VSYNC_o,
  output logic        DE_o,
  output logic        FID_o,
  output logic [10:0] xpos_o,
  output logic [10:0] ypos_o,
  output logic        sof_o,
  output logic        locked_o
);

  video_cfg_t  cfg_in, sh;
  logic [11:0] h_cnt, h_half;
  logic [10:0] v_cnt, field_lines;
  logic        degen, h_last, v_last, field_wrap, frame_wrap, resync;
  logic        interlaced, fid, hs_low, vs_low, h_in, v_in;
  logic [13:0] h_de_start, h_de_end;
  logic [12:0] v_de_start, v_de_end;
  logic        unused_reserved;

  assign cfg_in          = decode_cfg(hv_out_config, hv_out_config2, hv_out_config3[12:0]);
  assign unused_reserved = ^hv_out_config3[31:13];

`ifdef VIDEO_TX_INTERLACE_EN
  logic fid_out;
  assign interlaced  = sh.interlaced;
  assign field_lines = !interlaced ? sh.v_total :
                       (fid == FID_ODD) ? (sh.v_total >> 1) + 11'd1 : (sh.v_total >> 1);

  always_ff @(posedge PCLK_i) begin
    if (reset_i) begin
      fid     <= FID_ODD;
      fid_out <= FID_ODD;
    end else begin
      if (resync || frame_wrap) fid <= FID_ODD;
      else if (field_wrap)      fid <= FID_EVEN;
      fid_out <= fid;
    end
  end
  assign FID_o = fid_out;
`else
  logic unused_interlace;
  assign unused_interlace = sh.interlaced;
  assign interlaced       = 1'b0;
  assign fid              = FID_ODD;
  assign field_lines      = sh.v_total;
  assign FID_o            = FID_ODD;
`endif

  assign degen      = (sh.h_total < 12'd2) || (sh.v_total < 11'd2);
  assign h_last     = h_cnt >= sh.h_total - 12'd1;
  assign v_last     = v_cnt >= field_lines - 11'd1;
  assign field_wrap = h_last && v_last;
  // A degenerate config parks at frame start so the shadows keep reloading until it becomes valid.
  assign frame_wrap = degen || (field_wrap && (!interlaced || fid == FID_EVEN));

  video_tx_framelock u_framelock (
    .clk        (PCLK_i),
    .reset      (reset_i),
    .lock_en    (lock_en_i),
    .vsync_ref  (vsync_ref_i),
    .frame_wrap (frame_wrap),
    .resync     (resync),
    .locked     (locked_o)
  );

  always_ff @(posedge PCLK_i) begin
    if (reset_i || resync || frame_wrap) begin
      h_cnt <= '0;
      v_cnt <= '0;
      sh    <= cfg_in;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign h_half     = sh.h_total >> 1;
  assign h_de_start = 14'(sh.h_synclen) + 14'(sh.h_backporch);
  assign h_de_end   = h_de_start + 14'(sh.h_active);
  assign v_de_start = 13'(sh.v_synclen) + 13'(sh.v_backporch);
  assign v_de_end   = v_de_start + 13'(sh.v_active);
  assign hs_low     = h_cnt < 12'(sh.h_synclen);
  assign h_in       = (14'(h_cnt) >= h_de_start) && (14'(h_cnt) < h_de_end) && (h_cnt < sh.h_total);
  assign v_in       = (13'(v_cnt) >= v_de_start) && (13'(v_cnt) < v_de_end);

  // Even fields shift both vertical sync edges to mid-line.
  always_comb begin
    vs_low = v_cnt < 11'(sh.v_synclen);
    if (interlaced && fid == FID_EVEN) begin
      if (v_cnt == '0) vs_low = (sh.v_synclen != '0) && (h_cnt >= h_half);
      else vs_low = (v_cnt < 11'(sh.v_synclen)) ||
                    ((v_cnt == 11'(sh.v_synclen)) && (h_cnt < h_half));
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (reset_i || degen) begin
      HSYNC_o <= 1'b1;
      VSYNC_o <= 1'b1;
      DE_o    <= 1'b0;
      xpos_o  <= '0;
      ypos_o  <= '0;
      sof_o   <= 1'b0;
    end else begin
      HSYNC_o <= ~hs_low;
      VSYNC_o <= ~vs_low;
      DE_o    <= h_in && v_in;
      xpos_o  <= 11'(h_cnt - 12'(h_de_start));
      ypos_o  <= 11'(v_cnt - 11'(v_de_start));
      sof_o   <= (h_cnt == '0) && (v_cnt == '0) && (fid == FID_ODD);
    end
  end

endmodule

// File: doc/video_tx_timing_gen.md
VIDEO_TX_TIMING_GEN -- requirements
Module: video_tx_timing_gen

Interface
REQ-001 SHALL have port PCLK_i, input, 1, output pixel clock; the block's only clock.
REQ-002 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-003 SHALL have port hv_out_config, input, 32: [11:0] H_TOTAL, [23:12] H_ACTIVE, [31:24] H_SYNCLEN.
REQ-004 SHALL have port hv_out_config2, input, 32: [8:0] H_BACKPORCH, [19:9] V_TOTAL, [30:20] V_ACTIVE, [31] INTERLACED.
REQ-005 SHALL have port hv_out_config3, input, 32: [3:0] V_SYNCLEN, [12:4] V_BACKPORCH, [31:13] reserved.
REQ-006 SHALL have port vsync_ref_i, input, 1, one-cycle source frame-start pulse, already in the PCLK_i domain.
REQ-007 SHALL have port lock_en_i, input, 1, enables framelock to vsync_ref_i.
REQ-008 SHALL have outputs HSYNC_o and VSYNC_o, 1 bit each, active-low syncs.
REQ-009 SHALL have output DE_o, 1 bit, active video window.
REQ-010 SHALL have output FID_o, 1 bit, field ID: 1 = odd, 0 = even.
REQ-011 SHALL have outputs xpos_o and ypos_o, 11 bits each, active-area coordinates.
REQ-012 SHALL have output sof_o, 1 bit, one-cycle pulse at frame start.
REQ-013 SHALL have output locked_o, 1 bit, framelock achieved.

Function
REQ-014 SHALL run 12-bit h_cnt over 0..H_TOTAL-1 and 11-bit v_cnt over 0..field_lines-1; v_cnt advances when h_cnt wraps.
REQ-015 SHALL set field_lines to V_TOTAL when progressive; when INTERLACED, to V_TOTAL/2+1 for the odd field and V_TOTAL/2 for the even field; fields alternate, odd first.
REQ-016 SHALL assert HSYNC_o low while h_cnt < H_SYNCLEN.
REQ-017 SHALL assert VSYNC_o low while v_cnt < V_SYNCLEN; in the even field both VSYNC_o edges occur at h_cnt == H_TOTAL/2 instead of h_cnt == 0.
REQ-018 SHALL assert DE_o when H_SYNCLEN+H_BACKPORCH <= h_cnt < H_SYNCLEN+H_BACKPORCH+H_ACTIVE and V_SYNCLEN+V_BACKPORCH <= v_cnt < V_SYNCLEN+V_BACKPORCH+V_ACTIVE.
REQ-019 SHALL drive xpos_o = h_cnt-H_SYNCLEN-H_BACKPORCH and ypos_o = v_cnt-V_SYNCLEN-V_BACKPORCH, truncated to 11 bits.
REQ-020 SHALL register all outputs, giving one cycle of latency from counter state to output.
REQ-021 SHALL pulse sof_o for one cycle when counters enter h=0, v=0 of the odd field (every field when progressive).
REQ-022 SHALL copy all config words into shadow registers only at frame start and at reset; mid-frame config changes SHALL NOT affect the current frame.
REQ-023 SHALL hold counters at 0 with outputs inactive when shadowed H_TOTAL < 2 or V_TOTAL < 2.
REQ-024 SHALL never assert DE_o for any h_cnt >= H_TOTAL, even when the configured active window exceeds the total.

Framelock
REQ-025 SHALL run a lock FSM with states UNLOCKED, TRACKING and LOCKED, plus a 2-bit match counter.
REQ-026 SHALL count a match when vsync_ref_i arrives with lock_en_i=1 on the last cycle of a frame; no correction is applied.
REQ-027 SHALL resync on any other vsync_ref_i arrival with lock_en_i=1: next cycle h=0, v=0, FID odd, shadow reload, match counter cleared, state UNLOCKED.
REQ-028 SHALL enter TRACKING on the first match and LOCKED when the counter saturates at 3; locked_o = (state == LOCKED).
REQ-029 SHALL ignore vsync_ref_i when lock_en_i=0; deasserting lock_en_i SHALL return the FSM to UNLOCKED.
REQ-030 SHALL give resync priority when vsync_ref_i coincides with a natural shadow reload; the reload still occurs.

Reset
REQ-031 SHALL reset to: h_cnt=0, v_cnt=0, HSYNC_o=1, VSYNC_o=1, DE_o=0, FID_o=1, xpos_o=0, ypos_o=0, sof_o=0, locked_o=0, state UNLOCKED, shadows loaded from inputs.
REQ-032 SHALL let reset_i override vsync_ref_i in the same cycle; reset mid-frame SHALL restart at frame start on the following cycle.

Configuration
REQ-033 SHALL use macro VIDEO_TX_INTERLACE_EN: when defined, interlace per REQ-015/017; when undefined, INTERLACED is ignored, FID_o is tied to 1 and interlace logic is removed.

Structure
REQ-034 SHALL place config field bit positions, FID_ODD/FID_EVEN constants and the lock-state enum in shared package video_tx_pkg.
REQ-035 SHALL implement the lock FSM as sub-module video_tx_framelock.

Verification
REQ-036 SHALL cover 480p (858/720/62/60, V 525/480/6/30): HSYNC low 62 cycles, first DE at h=122, v=36, 720x480 DE cycles per frame.
REQ-037 SHALL cover 480i (858, V_TOTAL 525, INTERLACED): fields alternate 263/262 lines; even-field VSYNC edges at h=429.
REQ-038 SHALL cover lock_en_i=1 with vsync_ref_i every 450450 cycles in phase: locked_o rises after 3rd match; a one-time 10-cycle phase shift drops locked_o and resyncs.
REQ-039 SHALL cover H_ACTIVE changed mid-frame: current frame unchanged, new width applies from next sof_o.
REQ-040 SHALL cover reset_i at v=100 coincident with vsync_ref_i: reset values per REQ-031, then restart at h=0, v=0.
